// File: rtl/multiword_add_ctrl.sv
// Multi-word adder sequencer: streams WORDS operand words through one external
// WIDTH-bit combinational adder, rippling the carry word by word.
module multiword_add_ctrl #(
   parameter int WIDTH = 32,
   parameter int WORDS = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [WIDTH*WORDS-1:0] req_a,
   input  logic [WIDTH*WORDS-1:0] req_b,
   input  logic                   req_cin,
   output logic [WIDTH-1:0]       add_a,
   output logic [WIDTH-1:0]       add_b,
   output logic                   add_cin,
   input  logic [WIDTH-1:0]       add_s,
   input  logic                   add_cout,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [WIDTH*WORDS-1:0] rsp_s,
   output logic                   rsp_cout,
   output logic                   busy
);
   // state  | meaning
   // S_IDLE | waiting for a request, req_ready high
   // S_RUN  | one operand word per cycle through the external adder
   // S_DONE | result held on rsp_* until the consumer takes it

   localparam int TW = WIDTH * WORDS;
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   a_q, a_d;
   logic [TW-1:0]   b_q, b_d;
   logic [TW-1:0]   sum_q, sum_d;
   logic            carry_q, carry_d;
   logic            cout_q, cout_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [WIDTH-1:0] a_word, b_word;

   always_comb begin
      a_word = '0;
      b_word = '0;
      for (int k = 0; k < WORDS; k++) begin
         if (idx_q == IW'(k)) begin
            a_word = a_q[k*WIDTH +: WIDTH];
            b_word = b_q[k*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               a_d     = req_a;
               b_d     = req_b;
               carry_d = req_cin;
               idx_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            for (int k = 0; k < WORDS; k++) begin
               if (idx_q == IW'(k)) sum_d[k*WIDTH +: WIDTH] = add_s;
            end
            // idx stops at the last word; the final carry becomes rsp_cout
            if (idx_q == IDX_LAST) begin
               cout_d  = add_cout;
               state_d = S_DONE;
            end else begin
               carry_d = add_cout;
               idx_d   = idx_q + 1'b1;
            end
         end
         S_DONE: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         idx_q   <= idx_d;
      end
   end

   // rst gates req_ready so nothing can look accepted while reset is held
   assign req_ready = (state_q == S_IDLE) && !rst;
   assign add_a     = (state_q == S_RUN) ? a_word : '0;
   assign add_b     = (state_q == S_RUN) ? b_word : '0;
   assign add_cin   = (state_q == S_RUN) ? carry_q : 1'b0;
   assign rsp_valid = (state_q == S_DONE);
   assign rsp_s     = sum_q;
   assign rsp_cout  = cout_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Bench for multiword_add_ctrl (WIDTH=8, WORDS=4) with a behavioural adder on add_*.
module tb_multiword_add_ctrl;
   localparam int WIDTH = 8;
   localparam int WORDS = 4;
   localparam int TW    = WIDTH * WORDS;

   logic            clk = 1'b0;
   logic            rst;
   logic            req_valid, req_ready, req_cin;
   logic [TW-1:0]   req_a, req_b;
   logic [WIDTH-1:0] add_a, add_b, add_s;
   logic            add_cin, add_cout;
   logic            rsp_valid, rsp_ready, rsp_cout, busy;
   logic [TW-1:0]   rsp_s;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

   multiword_add_ctrl #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_s(add_s), .add_cout(add_cout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_s(rsp_s), .rsp_cout(rsp_cout), .busy(busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [TW:0] ref_sum(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                           input logic c);
      return {1'b0, a} + {1'b0, b} + {{TW{1'b0}}, c};
   endfunction

   // Issue one request from IDLE; returns the result seen when rsp_valid rises
   // and the number of edges after the accepting edge. Leaves the block in DONE.
   task automatic run_op(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic c,
                         input bit scramble, output logic [TW:0] res, output int lat);
      req_a = a; req_b = b; req_cin = c; req_valid = 1'b1;
      chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
      tick();
      req_valid = 1'b0;
      if (scramble) begin
         req_a = $urandom; req_b = $urandom; req_cin = ~c;
      end
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         tick();
         lat++;
      end
      res = {rsp_cout, rsp_s};
   endtask

   task automatic release_rsp();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   logic [TW:0]   res;
   int            lat;
   logic [TW:0]   expq[$];
   int            accepted, consumed, cyc;
   logic [TW-1:0] ra, rb;
   logic          rc;
   logic [TW:0]   e;

   initial begin
      rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
      req_a = '0; req_b = '0; req_cin = 1'b0;
      #1;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_ready", {63'd0, req_ready}, 64'd0);
      chk("rst_rsp", {31'd0, rsp_valid, rsp_cout, rsp_s}, 64'd0);
      tick(); tick();
      rst = 1'b0;
      tick();

      // byte carry into word 1
      run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, res, lat);
      chk("lat_ff_1", lat, 4);
      chk("sum_ff_1", res, 33'h0_0000_0100);
      release_rsp();
      chk("idle_after_rsp", {62'd0, busy, rsp_valid}, 64'd0);

      // carry ripples through all words
      run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, res, lat);
      chk("lat_ripple", lat, 4);
      chk("sum_ripple", res, 33'h1_0000_0000);

      // backpressure in DONE; a pending request must not be taken
      req_valid = 1'b1; req_a = 32'h1234_5678; req_b = 32'h1111_1111;
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", {63'd0, rsp_valid}, 64'd1);
         chk("hold_sum", {rsp_cout, rsp_s}, 33'h1_0000_0000);
         chk("hold_ready", {63'd0, req_ready}, 64'd0);
         chk("hold_add_zero", {add_cin, add_a, add_b}, 64'd0);
         tick();
      end
      req_valid = 1'b0;
      release_rsp();
      chk("hold_to_idle", {62'd0, busy, req_ready}, 64'd1);

      // reset during the second RUN cycle
      req_a = 32'hA5A5_A5A5; req_b = 32'h5A5A_5A5A; req_cin = 1'b1; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      chk("run2_add_a", add_a, 8'h5A + 8'h00 == 8'h00 ? 0 : 64'hA5);
      rst = 1'b1;
      #1;
      chk("rst_mid_out", {rsp_valid, busy, req_ready, add_cin, add_a, add_b}, 64'd0);
      chk("rst_mid_rsp", {rsp_cout, rsp_s}, 64'd0);
      tick();
      chk("rst_mid_hold", {62'd0, rsp_valid, busy}, 64'd0);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk("no_stale_valid", {63'd0, rsp_valid}, 64'd0);
         tick();
      end
      run_op(32'd1, 32'd2, 1'b0, 1'b0, res, lat);
      chk("post_rst_lat", lat, 4);
      chk("post_rst_sum", res, 33'd3);
      release_rsp();

      // inputs changed right after acceptance must not matter
      run_op(32'h8000_7FFF, 32'h8000_0001, 1'b0, 1'b1, res, lat);
      chk("capture_sum", res, ref_sum(32'h8000_7FFF, 32'h8000_0001, 1'b0));
      release_rsp();

      // random traffic with random consumer backpressure
      accepted = 0; consumed = 0; cyc = 0;
      while ((accepted < 1000 || consumed < accepted) && cyc < 40000) begin
         req_valid = (accepted < 1000) && ($urandom_range(3) != 0);
         ra = $urandom; rb = $urandom; rc = 1'($urandom);
         req_a = ra; req_b = rb; req_cin = rc;
         rsp_ready = ($urandom_range(2) != 0);
         #1;
         if (rsp_valid && rsp_ready) begin
            if (expq.size() == 0) chk("rand_dup_rsp", 64'd1, 64'd0);
            else begin
               e = expq.pop_front();
               chk("rand_sum", {rsp_cout, rsp_s}, e);
            end
            consumed++;
         end
         if (req_valid && req_ready) begin
            expq.push_back(ref_sum(ra, rb, rc));
            accepted++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      req_valid = 1'b0; rsp_ready = 1'b0;
      chk("rand_accepted", accepted, 1000);
      chk("rand_consumed", consumed, 1000);
      chk("rand_queue_empty", expq.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
